// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control bit positions,
// skid-buffer state encoding and the reference payload layout.
package pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CTRL_W = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Field order is the packing order used by exmem_pipe_stage for any width.
  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_REG_AW-1:0] rd;
  } exmem_payload_t;

  function automatic int payload_width(input int ctrl_w, input int data_w,
                                       input int reg_aw);
    return ctrl_w + 2 * data_w + reg_aw;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with flush; ready and valid come straight from flops
// so neither side sees a combinational path through this stage.
//
//   state    | meaning
//   ST_EMPTY | no entry held, outputs invalid
//   ST_BUSY  | main register m_q holds the head entry
//   ST_FULL  | m_q holds the head, s_q holds the next entry, input blocked
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_e      state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] s_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer     = in_valid_i & in_ready_q;
  assign out_xfer    = out_valid_q & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = m_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      // Held data is left in place; only the valid state is dropped.
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_q         <= in_data_i;
            state_q     <= ST_BUSY;
            out_valid_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            m_q <= in_data_i;
          end else if (in_xfer) begin
            s_q        <= in_data_i;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            m_q        <= s_q;
            state_q    <= ST_BUSY;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, x0 write
// guarding on the MEM side and a saturating backpressure cycle counter.
module exmem_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int CTRL_W   = 4,
  parameter int X0_GUARD = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_alu_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  input  logic [REG_AW-1:0] in_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_alu_o,
  output logic [DATA_W-1:0] out_wdata_o,
  output logic [REG_AW-1:0] out_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int PAY_W = payload_width(CTRL_W, DATA_W, REG_AW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_AW-1:0] rd;
  } payload_t;

  payload_t          in_pay;
  payload_t          m_pay;
  logic              m_valid;
  logic [CTRL_W-1:0] ctrl_gated;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  assign in_pay.ctrl  = in_ctrl_i;
  assign in_pay.alu   = in_alu_i;
  assign in_pay.wdata = in_wdata_i;
  assign in_pay.rd    = in_rd_i;

  pipe_skid_buf #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_pay),
    .out_valid_o(m_valid),
    .out_ready_i(out_ready_i),
    .out_data_o (m_pay)
  );

  // Bubbles must never write memory or the register file.
  always_comb begin
    ctrl_gated = m_pay.ctrl;
    if (X0_GUARD != 0 && m_pay.rd == '0) begin
      ctrl_gated[CTRL_REGWRITE] = 1'b0;
    end
    if (!m_valid) begin
      ctrl_gated = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !out_ready_i && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = m_valid;
  assign out_ctrl_o  = ctrl_gated;
  assign out_alu_o   = m_pay.alu;
  assign out_wdata_o = m_pay.wdata;
  assign out_rd_o    = m_pay.rd;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/exmem_pipe_stage.md
Name: exmem_pipe_stage

Overview:
- Parametrised successor to the fixed EX/MEM pipeline register.
- Carries WB/MEM control bits, ALU result, store data and destination register from EX to MEM.
- Adds a valid/ready handshake with a 2-entry skid buffer, flush (bubble insertion), x0 write guarding and a backpressure stall counter.
- Sits between the EX stage and the data-memory interface, so a slow memory can stall the pipe without combinational ready paths.

Parameters:
- DATA_W, 32, width of ALU result and store-data fields.
- REG_AW, 5, width of the destination register index.
- CTRL_W, 4, control vector width; bit0 RegWrite, bit1 MemtoReg, bit2 MemRead, bit3 MemWrite.
- X0_GUARD, 1, when 1 force RegWrite to 0 at output if rd == 0.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all held entries and any same-cycle input.
- in_valid_i  in  1  EX presents a valid entry.
- in_ready_o  out  1  stage can accept; registered, depends on state only.
- in_ctrl_i  in  CTRL_W  control bits.
- in_alu_i  in  DATA_W  ALU result.
- in_wdata_i  in  DATA_W  store data (reg_read_data_2).
- in_rd_i  in  REG_AW  destination register.
- out_valid_o  out  1  MEM-side entry valid.
- out_ready_i  in  1  MEM consumes the entry.
- out_ctrl_o  out  CTRL_W  control bits, gated (see Behaviour).
- out_alu_o  out  DATA_W  ALU result.
- out_wdata_o  out  DATA_W  store data.
- out_rd_o  out  REG_AW  destination register.
- stall_cnt_o  out  CNT_W  count of backpressure cycles.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i), sampled on the rising edge of clk_i. No asynchronous reset path.
- Storage: main register M drives the outputs; skid register S is the overflow entry.
- State machine: EMPTY, BUSY (M valid), FULL (M and S valid).
- in_xfer = in_valid_i & in_ready_o.
- out_xfer = out_valid_o & out_ready_i.
- in_ready_o = (state != FULL).
- out_valid_o = (state != EMPTY).
- Transitions:
  - EMPTY: in_xfer -> M loads input, go to BUSY.
  - BUSY, in_xfer & out_xfer -> M loads input, stay in BUSY.
  - BUSY, in_xfer only -> S loads input, go to FULL.
  - BUSY, out_xfer only -> go to EMPTY.
  - FULL: no input is accepted. out_xfer -> M loads S, go to BUSY.
- Latency: an input accepted in EMPTY, or in BUSY with concurrent out_xfer, appears at the outputs the next cycle.
- Ordering is strict FIFO; there is no loss or duplication.
- Flush: flush_i=1 -> state goes to EMPTY next cycle from any state. Same-cycle input is discarded even if in_xfer. Flush wins over in_xfer and out_xfer. A same-cycle out_xfer still counts as consumed by MEM.
- Reset: priority over flush. state=EMPTY; M, S and stall_cnt_o cleared to 0; in_ready_o=1; out_valid_o=0; all out_* fields 0. Reset mid-transfer drops all entries.
- Output gating:
  - out_ctrl_o = 0 whenever out_valid_o=0, so bubbles never write memory or the register file.
  - If X0_GUARD=1 and out_rd_o==0, out_ctrl_o[0] = 0.
  - Data fields hold their last value when invalid; they are not zeroed except by reset.
- Stall counter: increments by 1 each cycle with out_valid_o & ~out_ready_i. Saturates at 2^CNT_W-1. Cleared only by rst_i; flush does not clear it.
- Holding: out_* fields stay stable while out_valid_o=1 and out_ready_i=0.
- Input fields are don't-care when in_valid_i=0.

Decomposition:
- Shared package pipe_pkg holds:
  - control bit index constants CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3;
  - the state encoding typedef (EMPTY/BUSY/FULL);
  - the packed payload struct {ctrl, alu, wdata, rd}.
- One sub-module, pipe_skid_buf: generic payload-width skid buffer with flush.
- exmem_pipe_stage wraps pipe_skid_buf and adds output gating and the stall counter.

Test Plan:
- Reset: assert rst_i 2 cycles mid-FULL -> out_valid_o=0, in_ready_o=1, all outputs 0, stall_cnt_o=0.
- Streaming: in_valid_i=1 with ctrl=4'b0001, alu=0x10,0x20,0x30, rd=5; out_ready_i=1 -> outputs 0x10,0x20,0x30 on consecutive cycles with 1-cycle latency. in_ready_o stays 1.
- Backpressure: fill A=0x11, B=0x22 with out_ready_i=0 for 3 cycles:
  - FULL reached, in_ready_o=0;
  - out holds A;
  - stall_cnt_o=3.
  - Then release -> A then B; no loss.
- Flush in FULL, with in_valid_i=1 carrying C=0x33 in the same cycle -> next cycle out_valid_o=0, out_ctrl_o=0. C never appears. stall_cnt_o unchanged.
- x0 guard: rd=0 with ctrl=4'b0001 -> out_ctrl_o[0]=0. With X0_GUARD=0 -> out_ctrl_o[0]=1. rd=7 -> bit passes in both cases.
- Counter saturation: CNT_W=3, 10 stall cycles -> stall_cnt_o=7 and stays 7.
